// File: rtl/saturation_ctrl.sv
// rtl/saturation_ctrl.sv - symmetric signed clamp with deferred limit, windowed clip count and alarm
module saturation_ctrl #(
   parameter int DATA_WIDTH  = 16,
   parameter int CNT_WIDTH   = 16,
   parameter int WINDOW_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   input  logic [DATA_WIDTH-2:0] max_val_in,
   input  logic                  max_val_wr,
   input  logic [CNT_WIDTH-1:0]  alarm_thresh,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  clip,
   output logic [CNT_WIDTH-1:0]  clip_count,
   output logic                  window_done,
   output logic                  alarm
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ALARM    = 2'd1,
      CLEARING = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0]   ACC_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WINDOW_LOG2-1:0] WIN_ONE = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-2:0]  lim;
   logic [DATA_WIDTH-2:0]  shadow;
   logic                   pending;
   logic [WINDOW_LOG2-1:0] win_cnt;
   logic [CNT_WIDTH-1:0]   acc;
   state_t                 state;
   state_t                 state_nxt;

   logic signed [DATA_WIDTH:0] din_ext;
   logic signed [DATA_WIDTH:0] pos_lim;
   logic signed [DATA_WIDTH:0] neg_lim;
   logic                       over;
   logic                       under;
   logic                       clip_now;
   logic [DATA_WIDTH-1:0]      sat_val;
   logic                       wrap;
   logic [CNT_WIDTH-1:0]       acc_sat;
   logic [CNT_WIDTH-1:0]       win_total;

   // One extra bit so that -lim and the most negative input compare without overflow.
   assign din_ext  = $signed({din[DATA_WIDTH-1], din});
   assign pos_lim  = $signed({2'b00, lim});
   assign neg_lim  = -pos_lim;
   assign over     = din_ext > pos_lim;
   assign under    = din_ext < neg_lim;
   assign clip_now = over | under;

   always_comb begin
      sat_val = din;
      if (over) begin
         sat_val = pos_lim[DATA_WIDTH-1:0];
      end else if (under) begin
         sat_val = neg_lim[DATA_WIDTH-1:0];
      end
   end

   assign wrap      = din_valid && (win_cnt == {WINDOW_LOG2{1'b1}});
   assign acc_sat   = (acc == {CNT_WIDTH{1'b1}}) ? acc : acc + ACC_ONE;
   assign win_total = clip_now ? acc_sat : acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         dout        <= '0;
         dout_valid  <= 1'b0;
         clip        <= 1'b0;
         clip_count  <= '0;
         window_done <= 1'b0;
         lim         <= '1;
         shadow      <= '1;
         pending     <= 1'b0;
         win_cnt     <= '0;
         acc         <= '0;
      end else begin
         dout_valid  <= din_valid;
         clip        <= din_valid & clip_now;
         window_done <= wrap;
         if (din_valid) begin
            dout    <= sat_val;
            win_cnt <= win_cnt + WIN_ONE;
            if (wrap) begin
               clip_count <= win_total;
               acc        <= '0;
            end else if (clip_now) begin
               acc <= acc_sat;
            end
         end
         // A write landing on the wrap cycle itself must wait for the following boundary.
         if (wrap && pending) begin
            lim <= shadow;
         end
         if (max_val_wr) begin
            shadow  <= max_val_in;
            pending <= 1'b1;
         end else if (wrap) begin
            pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (wrap) begin
         case (state)
            IDLE:     state_nxt = (win_total >= alarm_thresh) ? ALARM : IDLE;
            ALARM:    state_nxt = (win_total <  alarm_thresh) ? CLEARING : ALARM;
            CLEARING: state_nxt = (win_total >= alarm_thresh) ? ALARM : IDLE;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   assign alarm = (state == ALARM) || (state == CLEARING);

endmodule

// File: tb/tb_saturation_ctrl.sv
// tb/tb_saturation_ctrl.sv - scoreboard bench for saturation_ctrl
module tb_saturation_ctrl;

   localparam int DW = 8;
   localparam int CW = 4;
   localparam int WL = 2;

   logic          clk;
   logic          rst;
   logic [DW-1:0] din;
   logic          din_valid;
   logic [DW-2:0] max_val_in;
   logic          max_val_wr;
   logic [CW-1:0] alarm_thresh;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          clip;
   logic [CW-1:0] clip_count;
   logic          window_done;
   logic          alarm;

   saturation_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .WINDOW_LOG2(WL)) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .din_valid    (din_valid),
      .max_val_in   (max_val_in),
      .max_val_wr   (max_val_wr),
      .alarm_thresh (alarm_thresh),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .clip         (clip),
      .clip_count   (clip_count),
      .window_done  (window_done),
      .alarm        (alarm)
   );

   typedef struct {
      int dout;
      int clip;
      int wd;
      int cc;
      int al;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   pos = 0;
   int   cur_cc = 0;
   int   cur_al = 0;
   int   nxt_cc = 0;
   int   nxt_al = 0;
   int   last_dout = 0;

   initial clk = 1'b0;
   always #4 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (dout_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_dout_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("dout", int'($signed(dout)), e.dout);
            check("clip", int'(clip), e.clip);
            check("window_done", int'(window_done), e.wd);
            check("clip_count", int'(clip_count), e.cc);
            check("alarm", int'(alarm), e.al);
         end
      end else if (window_done === 1'b1) begin
         check("window_done_without_valid", 1, 0);
      end
   end

   task automatic win_end(input int cc, input int al);
      nxt_cc = cc;
      nxt_al = al;
   endtask

   task automatic send(input int d, input int ed, input int ec);
      exp_t e;
      din       = d[DW-1:0];
      din_valid = 1'b1;
      e.dout    = ed;
      e.clip    = ec;
      if (pos == 3) begin
         e.wd   = 1;
         cur_cc = nxt_cc;
         cur_al = nxt_al;
      end else begin
         e.wd = 0;
      end
      e.cc = cur_cc;
      e.al = cur_al;
      sb.push_back(e);
      last_dout = ed;
      pos = (pos + 1) % 4;
      @(posedge clk);
      #1;
      din_valid  = 1'b0;
      max_val_wr = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("gap_idle", int'({dout_valid, clip}), 0);
         check("gap_dout_hold", int'($signed(dout)), last_dout);
      end
   endtask

   task automatic chk_reset();
      check("reset_outputs", int'({dout, dout_valid, clip, clip_count, window_done, alarm}), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      din          = 8'd50;
      din_valid    = 1'b1;
      max_val_in   = '0;
      max_val_wr   = 1'b0;
      alarm_thresh = 4'd15;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      din_valid = 1'b0;

      // reset limit, deferred write of 15 at sample 1
      send(100, 100, 0);
      max_val_in = 7'd15; max_val_wr = 1'b1;
      send(-128, -127, 1);
      send(18, 18, 0);
      win_end(1, 0); send(20, 20, 0);
      send(18, 15, 1); send(-20, -15, 1); send(-15, -15, 0);
      win_end(2, 0); send(15, 15, 0);

      // window counts
      send(18, 15, 1); send(1, 1, 0); send(-16, -15, 1);
      win_end(2, 0); send(0, 0, 0);
      send(127, 15, 1); send(127, 15, 1); send(127, 15, 1);
      win_end(4, 0); send(127, 15, 1);

      // hysteresis: 3,1,1 then 3,1,2
      alarm_thresh = 4'd2;
      send(20, 15, 1); send(20, 15, 1); send(20, 15, 1);
      win_end(3, 1); send(0, 0, 0);
      send(20, 15, 1); send(0, 0, 0); send(0, 0, 0);
      win_end(1, 1); send(0, 0, 0);
      send(20, 15, 1); send(0, 0, 0); send(0, 0, 0);
      win_end(1, 0); send(0, 0, 0);
      send(20, 15, 1); send(20, 15, 1); send(20, 15, 1);
      win_end(3, 1); send(0, 0, 0);
      send(20, 15, 1); send(0, 0, 0); send(0, 0, 0);
      win_end(1, 1); send(0, 0, 0);
      send(20, 15, 1); send(-20, -15, 1); send(0, 0, 0);
      win_end(2, 1); send(0, 0, 0);

      // gapped window with a write on its wrap cycle
      send(-16, -15, 1); gap(3);
      send(3, 3, 0); gap(3);
      send(0, 0, 0); gap(3);
      max_val_in = 7'd100; max_val_wr = 1'b1;
      win_end(2, 1); send(16, 15, 1); gap(3);
      send(100, 15, 1); send(0, 0, 0); send(0, 0, 0);
      win_end(1, 1); send(0, 0, 0);
      send(100, 100, 0); send(120, 100, 1); send(-128, -100, 1);
      win_end(2, 1); send(0, 0, 0);

      // reset mid-window with alarm set
      send(120, 100, 1); send(0, 0, 0);
      rst       = 1'b1;
      din       = 8'd120;
      din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset();
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk_reset();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      din_valid = 1'b0;
      pos       = 0;
      cur_cc    = 0;
      cur_al    = 0;

      // fresh window at reset limit; write lim=0 for the next one
      max_val_in = 7'd0; max_val_wr = 1'b1;
      send(120, 120, 0); send(-128, -127, 1); send(0, 0, 0);
      win_end(1, 0); send(0, 0, 0);
      send(5, 0, 1); send(0, 0, 0); send(-1, 0, 1);
      win_end(2, 1); send(0, 0, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
